pc_gen: RTL and testbench

//  Parametrised fetch program-counter generator for the IF stage; successor to the single-redirect PC.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_gen_ras_stack.sv | 64 ++++++
 rtl/pc_gen.sv | 133 +++++++++++++
 tb/tb_pc_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: default widths, the instruction step,
// the alignment mask and the next-PC source encoding.
package pc_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam int          PC_STEP       = 4;
    localparam logic [1:0]  IALIGN_MASK   = 2'b11;

    typedef enum logic [2:0] {
        NPC_TRAP  = 3'd0,
        NPC_REDIR = 3'd1,
        NPC_HOLD  = 3'd2,
        NPC_RAS   = 3'd3,
        NPC_CALL  = 3'd4,
        NPC_SEQ   = 3'd5
    } npc_sel_e;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return address stack. The pointer names the current top entry; a push on a full
// stack silently overwrites the oldest entry. Push and pop together replace the top in place.
module ras_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_push_data,
    output logic [W-1:0]  o_top,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic          w_empty;
    logic          w_pop_ok;

    assign w_empty  = (r_count == CW'(0));
    assign w_pop_ok = i_pop && !w_empty;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (i_reset || i_flush) begin
            r_ptr   <= PW'(0);
            r_count <= CW'(0);
        end else if (w_pop_ok && i_push) begin
            r_ptr   <= r_ptr;
            r_count <= r_count;
        end else if (w_pop_ok) begin
            r_ptr   <= r_ptr - PW'(1);
            r_count <= r_count - CW'(1);
        end else if (i_push) begin
            r_ptr   <= r_ptr + PW'(1);
            r_count <= (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);
        end else begin
            r_ptr   <= r_ptr;
            r_count <= r_count;
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (!i_reset && !i_flush) begin
            if (w_pop_ok && i_push) begin
                r_mem[r_ptr] <= i_push_data;
            end else if (i_push) begin
                r_mem[r_ptr + PW'(1)] <= i_push_data;
            end
        end
    end

    assign o_top   = r_mem[r_ptr];
    assign o_count = r_count;
    assign o_empty = w_empty;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: prioritised next-PC select (trap, redirect, stall hold,
// return prediction, call prediction, sequential) plus the PC register and a return address stack.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter int              RAS_DEPTH = 4,
    localparam int             CW        = $clog2(RAS_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            mmm_stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            pred_call,
    input  logic [XLEN-1:0] pred_call_target,
    input  logic            pred_ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_4,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [CW-1:0]   ras_count
);

    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(IALIGN_MASK);

    logic [XLEN-1:0] r_pc;
    logic            r_pred_taken;
    npc_sel_e        w_sel;
    logic [XLEN-1:0] w_pc_4;
    logic [XLEN-1:0] w_ras_top;
    logic [CW-1:0]   w_ras_count;
    logic            w_ras_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;

    assign w_pc_4 = r_pc + XLEN'(PC_STEP);

    // Next-PC source priority; a return on an empty stack falls through to call or sequential
    always_comb begin
        w_sel = NPC_SEQ;
        if (trap_valid) begin
            w_sel = NPC_TRAP;
        end else if (redirect_valid) begin
            w_sel = NPC_REDIR;
        end else if (stall || mmm_stall) begin
            w_sel = NPC_HOLD;
        end else if (pred_ret && !w_ras_empty) begin
            w_sel = NPC_RAS;
        end else if (pred_call) begin
            w_sel = NPC_CALL;
        end else begin
            w_sel = NPC_SEQ;
        end
    end

    assign w_pop   = (w_sel == NPC_RAS);
    assign w_push  = (w_sel == NPC_CALL) || ((w_sel == NPC_RAS) && pred_call);
    assign w_flush = (w_sel == NPC_TRAP);

    ras_stack #(
        .W     (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .i_reset     (reset),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_4),
        .o_top       (w_ras_top),
        .o_count     (w_ras_count),
        .o_empty     (w_ras_empty)
    );

    // PC register and prediction flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_VEC;
            r_pred_taken <= 1'b0;
        end else begin
            case (w_sel)
                NPC_TRAP: begin
                    r_pc         <= trap_vec & ALIGN;
                    r_pred_taken <= 1'b0;
                end
                NPC_REDIR: begin
                    r_pc         <= redirect_addr & ALIGN;
                    r_pred_taken <= 1'b0;
                end
                NPC_HOLD: begin
                    r_pc         <= r_pc;
                    r_pred_taken <= r_pred_taken;
                end
                NPC_RAS: begin
                    r_pc         <= w_ras_top;
                    r_pred_taken <= 1'b1;
                end
                NPC_CALL: begin
                    r_pc         <= pred_call_target & ALIGN;
                    r_pred_taken <= 1'b1;
                end
                default: begin
                    r_pc         <= w_pc_4;
                    r_pred_taken <= 1'b0;
                end
            endcase
        end
    end

    // Same-cycle prediction target, independent of stall/redirect gating
    always_comb begin
        pred_target = w_pc_4;
        if (pred_ret && !w_ras_empty) begin
            pred_target = w_ras_top;
        end else if (pred_call) begin
            pred_target = pred_call_target & ALIGN;
        end else begin
            pred_target = w_pc_4;
        end
    end

    assign pc         = r_pc;
    assign pc_4       = w_pc_4;
    assign pred_taken = r_pred_taken;
    assign ras_count  = w_ras_count;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a queue-based reference model checked against the DUT every
// cycle, plus literal expectations on the model after each scenario step.
module tb_pc_gen;

    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0, stall = 1'b0, mmm_stall = 1'b0;
    logic        trap_valid = 1'b0, redirect_valid = 1'b0, pred_call = 1'b0, pred_ret = 1'b0;
    logic [31:0] trap_vec = 32'h0, redirect_addr = 32'h0, pred_call_target = 32'h0;
    logic [31:0] pc, pc_4, pred_target;
    logic        pred_taken;
    logic [2:0]  ras_count;

    pc_gen #(.XLEN(32), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .mmm_stall(mmm_stall),
        .trap_valid(trap_valid), .trap_vec(trap_vec),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .pred_call(pred_call), .pred_call_target(pred_call_target), .pred_ret(pred_ret),
        .pc(pc), .pc_4(pc_4), .pred_taken(pred_taken), .pred_target(pred_target),
        .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_pc = 32'h0;
    bit          m_pt = 1'b0;
    logic [31:0] m_ras [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("pc_4", pc_4, m_pc + 32'd4);
            check("pred_taken", {31'b0, pred_taken}, {31'b0, m_pt});
            check("ras_count", {29'b0, ras_count}, m_ras.size());
            if (pred_ret && m_ras.size() > 0)
                check("pred_target_ret", pred_target, m_ras[$]);
            else if (pred_call)
                check("pred_target_call", pred_target, pred_call_target & ~32'h3);
        end
    end

    task automatic drive(input bit r, input bit st, input bit ms, input bit tv_v,
                         input logic [31:0] tv, input bit rd_v, input logic [31:0] ra,
                         input bit pcl, input logic [31:0] tgt, input bit prt);
        logic [31:0] t;
        @(negedge clk);
        #1;
        reset = r; stall = st; mmm_stall = ms;
        trap_valid = tv_v; trap_vec = tv;
        redirect_valid = rd_v; redirect_addr = ra;
        pred_call = pcl; pred_call_target = tgt; pred_ret = prt;
        if (r) begin
            m_pc = RV; m_pt = 1'b0; m_ras.delete(); chk_en = 1'b1;
        end else if (tv_v) begin
            m_pc = tv & ~32'h3; m_pt = 1'b0; m_ras.delete();
        end else if (rd_v) begin
            m_pc = ra & ~32'h3; m_pt = 1'b0;
        end else if (st || ms) begin
            m_pc = m_pc;
        end else if (prt && m_ras.size() > 0) begin
            t = m_ras.pop_back();
            if (pcl) m_ras.push_back(m_pc + 32'd4);
            m_pc = t; m_pt = 1'b1;
        end else if (pcl) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) m_ras.delete(0);
            m_pc = tgt & ~32'h3; m_pt = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4; m_pt = 1'b0;
        end
    endtask

    task automatic seq();                       drive(0,0,0,0,0,0,0,0,0,0); endtask
    task automatic rst();                       drive(1,0,0,0,0,0,0,0,0,0); endtask
    task automatic stl(input bit s, input bit m); drive(0,s,m,0,0,0,0,0,0,0); endtask
    task automatic redir(input logic [31:0] a); drive(0,0,0,0,0,1,a,0,0,0); endtask
    task automatic trap(input logic [31:0] v);  drive(0,0,0,1,v,0,0,0,0,0); endtask
    task automatic call(input logic [31:0] t);  drive(0,0,0,0,0,0,0,1,t,0); endtask
    task automatic ret();                       drive(0,0,0,0,0,0,0,0,0,1); endtask
    task automatic callret(input logic [31:0] t); drive(0,0,0,0,0,0,0,1,t,1); endtask

    initial begin
        // Reset and release
        rst(); rst();
        check("lit_reset_pc", m_pc, 32'h100);
        seq(); check("lit_rel1", m_pc, 32'h104);
        seq(); check("lit_rel2", m_pc, 32'h108);

        // Stall / mmm_stall hold, with an ignored call during stall
        redir(32'h10);
        for (int i = 0; i < 3; i++) stl(1'b1, 1'b0);
        drive(0,1,0,0,0,0,0,1,32'h900,0);
        for (int i = 0; i < 2; i++) stl(1'b0, 1'b1);
        check("lit_hold", m_pc, 32'h10);
        seq(); check("lit_after_stall", m_pc, 32'h14);

        // Redirect overrides stall; trap overrides redirect and flushes the RAS
        drive(0,1,0,0,0,1,32'h203,0,0,0);
        check("lit_redir_align", m_pc, 32'h200);
        call(32'h300);
        check("lit_cnt_pre_trap", m_ras.size(), 1);
        drive(0,0,0,1,32'h80,1,32'h500,1,32'h700,1);
        check("lit_trap_pc", m_pc, 32'h80);
        check("lit_trap_cnt", m_ras.size(), 0);

        // Single call/return
        redir(32'h40);
        call(32'h400);
        check("lit_call_pc", m_pc, 32'h400);
        seq(); seq(); ret();
        check("lit_ret_pc", m_pc, 32'h44);

        // Nested calls overflowing a 4-deep stack
        redir(32'h0);
        for (int i = 1; i <= 5; i++) call(32'(i) * 32'h100);
        check("lit_nest_cnt", m_ras.size(), 4);
        ret(); check("lit_ret1", m_pc, 32'h404);
        ret(); check("lit_ret2", m_pc, 32'h304);
        ret(); check("lit_ret3", m_pc, 32'h204);
        ret(); check("lit_ret4", m_pc, 32'h104);
        ret(); check("lit_ret5_seq", m_pc, 32'h108);
        check("lit_ret5_pt", {31'b0, m_pt}, 32'h0);
        callret(32'h600);
        check("lit_callret_empty", m_pc, 32'h600);

        // Wrap-around and call+return replace
        redir(32'hFFFF_FFFC);
        seq(); check("lit_wrap", m_pc, 32'h0);
        trap(32'h4C);
        call(32'h1000);
        redir(32'h60);
        callret(32'h2000);
        check("lit_cr_pc", m_pc, 32'h50);
        check("lit_cr_top", m_ras[$], 32'h64);
        ret(); check("lit_cr_ret", m_pc, 32'h64);

        // Reset mid-operation beats every other input
        call(32'h800);
        drive(1,1,0,1,32'h80,1,32'h90,1,32'h700,1);
        check("lit_midrst", m_pc, 32'h100);
        seq();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
